shift_req_sequencer: RTL and testbench

//  Owns the single shared bar_shift_lr_16b instance and sequences it for two requesters (req0, req1).

---
 rtl/shift_req_sequencer_pkg.sv | 36 +++
 rtl/shift_req_sequencer_rr_arb2.sv | 34 +++
 rtl/shift_req_sequencer.sv | 148 ++++++++++++++
 tb/tb_shift_req_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_req_sequencer_pkg.sv
// shift_pkg: shared types and constants for the shift request sequencer.
// Contents: op encodings, FSM state enum, datapath widths, EXEC1 lr helper.
// No ports (package only).
package shift_pkg;

  localparam int DW      = 16;
  localparam int SHAMT_W = 4;

  // Op encoding doubles as the shifter lr code for the three native shifts.
  typedef enum logic [1:0] {
    OP_ROR = 2'b00,
    OP_LSL = 2'b01,
    OP_LSR = 2'b10,
    OP_ASR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_EXEC1 = 2'b01,
    S_EXEC2 = 2'b10,
    S_RESP  = 2'b11
  } state_t;

  // lr code for the first pass. A rotate starts with a logical right shift
  // (the left-shifted half is OR-ed in by the second pass). Without rotate
  // support the shifter is left idle (lr 00) for op 00.
  function automatic logic [1:0] exec1_lr(input op_t op, input bit ror_en);
    logic [1:0] lr;
    lr = 2'(op);
    if (op == OP_ROR) begin
      lr = ror_en ? 2'(OP_LSR) : 2'b00;
    end
    return lr;
  endfunction

endpackage

// File: rtl/shift_req_sequencer_rr_arb2.sv
// rr_arb2: two-way arbiter producing a one-hot grant (round-robin or fixed priority).
// Ports: clk, rst_n, valid[1:0] requests, advance (grant consumed this cycle), grant[1:0].
// Grant is combinational from valid and the pointer; pointer updates on advance.
module rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr = index favoured when both requesters are valid
  logic ptr;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant the pointer moves to the requester that lost, so a
  // persistent requester cannot be starved. Fixed priority pins it to req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= (FIXED_PRIO == 0) ? grant[0] : 1'b0;
    end
  end

endmodule

// File: rtl/shift_req_sequencer.sv
// shift_req_sequencer: arbitrates two requesters onto one shared combinational
// barrel shifter, runs one or two shifter passes, returns a tagged result.
// Ports: reqN_valid/ready/data/shamt/op (N=0,1) request side; rsp_valid/ready/
//   data/id/err response side; shf_a/sel/lr out to shifter, shf_b back from it.
// Macro SHIFT_SEQ_ROR_EN: op 00 performs rotate-right (two passes when shamt!=0);
//   undefined, op 00 bypasses the shifter and answers with the operand and err=1.
module shift_req_sequencer
  import shift_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DW-1:0]      req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DW-1:0]      req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_id,
  output logic               rsp_err,
  output logic [DW-1:0]      shf_a,
  output logic [SHAMT_W-1:0] shf_sel,
  output logic [1:0]         shf_lr,
  input  logic [DW-1:0]      shf_b
);

`ifdef SHIFT_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  state_t             state, state_nxt;
  logic [1:0]         grant;
  logic               accept;
  logic [DW-1:0]      op_data;
  logic [SHAMT_W-1:0] op_shamt;
  op_t                op_op;
  logic               op_id;
  logic [DW-1:0]      result;
  logic               err;
  logic               bypass;
  logic               two_pass;

  assign accept   = (state == S_IDLE) && (grant != 2'b00);
  assign bypass   = (op_op == OP_ROR) && !ROR_EN;
  assign two_pass = ROR_EN && (op_op == OP_ROR) && (op_shamt != '0);

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .advance(accept),
    .grant  (grant)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC1;
      S_EXEC1: state_nxt = two_pass ? S_EXEC2 : S_RESP;
      S_EXEC2: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: shifter drive comes only from latched operands, never from
  // the request inputs, so there is no combinational req->shf path.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    shf_a      = '0;
    shf_sel    = '0;
    shf_lr     = 2'b00;
    case (state)
      S_IDLE: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
      end
      S_EXEC1: begin
        shf_a   = op_data;
        shf_sel = op_shamt;
        shf_lr  = exec1_lr(op_op, ROR_EN);
      end
      S_EXEC2: begin
        // left shift by 16-shamt; 4-bit wrap is exact since shamt != 0 here
        shf_a   = op_data;
        shf_sel = SHAMT_W'(0) - op_shamt;
        shf_lr  = 2'(OP_LSL);
      end
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_data  <= '0;
      op_shamt <= '0;
      op_op    <= OP_ROR;
      op_id    <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        op_id    <= grant[1];
        op_data  <= grant[1] ? req1_data  : req0_data;
        op_shamt <= grant[1] ? req1_shamt : req0_shamt;
        op_op    <= op_t'(grant[1] ? req1_op : req0_op);
      end
      if (state == S_EXEC1) begin
        result <= bypass ? op_data : shf_b;
        err    <= bypass;
      end
      if (state == S_EXEC2) begin
        result <= result | shf_b;
      end
    end
  end

  assign rsp_data = result;
  assign rsp_id   = op_id;
  assign rsp_err  = err;

endmodule

// File: tb/tb_shift_req_sequencer.sv
// tb_shift_req_sequencer: directed and randomized checks of shift_req_sequencer
// against a behavioural model of arbitration, latency and shift results.
// Includes a combinational model of the external barrel shifter.
module tb_shift_req_sequencer;

  localparam int FIXED_PRIO = 0;
`ifdef SHIFT_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id, rsp_err;
  logic [15:0] shf_a, shf_b;
  logic [3:0]  shf_sel;
  logic [1:0]  shf_lr;

  int n_cmp;
  int n_bad;
  logic ptr_m;   // model: favoured requester when both valid

  shift_req_sequencer #(.FIXED_PRIO(FIXED_PRIO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .shf_a(shf_a), .shf_sel(shf_sel), .shf_lr(shf_lr), .shf_b(shf_b)
  );

  // external shifter: 01 LSL, 10 LSR, 11 ASR, 00 pass-through
  always_comb begin
    case (shf_lr)
      2'b01:   shf_b = shf_a << shf_sel;
      2'b10:   shf_b = shf_a >> shf_sel;
      2'b11:   shf_b = 16'($signed(shf_a) >>> shf_sel);
      default: shf_b = shf_a;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference result {err, data} from the op definitions
  function automatic logic [16:0] ref_calc(input logic [15:0] d, input logic [3:0] s,
                                           input logic [1:0] op);
    logic [15:0] r;
    logic        e;
    e = 1'b0;
    case (op)
      2'b01: r = d << s;
      2'b10: r = d >> s;
      2'b11: r = 16'($signed(d) >>> s);
      default: begin
        if (ROR_EN) begin
          r = (d >> s) | (d << (5'd16 - {1'b0, s}));
        end else begin
          r = d;
          e = 1'b1;
        end
      end
    endcase
    return {e, r};
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_ready"},     32'({req1_ready, req0_ready}), 32'd0);
    chk({tag, "_shf_lr"},    32'(shf_lr), 32'd0);
    chk({tag, "_shf_a"},     32'(shf_a), 32'd0);
    chk({tag, "_shf_sel"},   32'(shf_sel), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data), 32'd0);
  endtask

  // One full transaction. Called #1 after a posedge with the DUT in IDLE.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [15:0] d0, input logic [3:0] s0, input logic [1:0] o0,
                        input logic [15:0] d1, input logic [3:0] s1, input logic [1:0] o1,
                        input int hold);
    logic        w;
    logic [15:0] d;
    logic [3:0]  s;
    logic [1:0]  o;
    logic [16:0] exp_r;
    logic [1:0]  exp_lr;
    int          passes;
    int          cnt;
    req0_valid = v0; req0_data = d0; req0_shamt = s0; req0_op = o0;
    req1_valid = v1; req1_data = d1; req1_shamt = s1; req1_op = o1;
    rsp_ready  = 1'b0;
    w = (v0 && v1) ? ptr_m : v1;
    #1;
    chk("grant", 32'({req1_ready, req0_ready}), w ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ptr_m  = (FIXED_PRIO == 0) ? ~w : 1'b0;
    d      = w ? d1 : d0;
    s      = w ? s1 : s0;
    o      = w ? o1 : o0;
    exp_r  = ref_calc(d, s, o);
    passes = (ROR_EN && o == 2'b00 && s != 4'd0) ? 2 : 1;
    exp_lr = (o == 2'b00) ? (ROR_EN ? 2'b10 : 2'b00) : o;
    chk("exec1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec1_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("exec1_shf_lr", 32'(shf_lr), 32'(exp_lr));
    if (exp_lr != 2'b00) begin
      chk("exec1_shf_a", 32'(shf_a), 32'(d));
      chk("exec1_shf_sel", 32'(shf_sel), 32'(s));
    end
    cnt = 0;
    while (!rsp_valid && cnt < 8) begin
      @(posedge clk);
      #1;
      cnt++;
      if (passes == 2 && cnt == 1) begin
        chk("exec2_shf_lr", 32'(shf_lr), 32'd1);
        chk("exec2_shf_sel", 32'(shf_sel), 32'(5'd16 - {1'b0, s}));
      end
    end
    chk("latency", 32'(cnt), 32'(passes));
    if (!rsp_valid) return;
    chk("rsp_data", 32'(rsp_data), 32'(exp_r[15:0]));
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_err", 32'(rsp_err), 32'(exp_r[16]));
    chk("resp_shf_lr", 32'(shf_lr), 32'd0);
    if (hold > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'({rsp_id, rsp_err, rsp_data}), 32'({w, exp_r[16], exp_r[15:0]}));
      chk("hold_ready", 32'({req1_ready, req0_ready}), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] rd0, rd1;
    logic [3:0]  rs0, rs1;
    logic [1:0]  ro0, ro1, rv;
    n_cmp = 0;
    n_bad = 0;
    ptr_m = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_op = '0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_op = '0;
    rsp_ready  = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed shift results
    run_op(1, 0, 16'hA5A5, 4'd4, 2'b01, 16'h0000, 4'd0, 2'b00, 0);
    run_op(0, 1, 16'h0000, 4'd0, 2'b00, 16'hA5A5, 4'd3, 2'b11, 0);
    run_op(0, 1, 16'h0000, 4'd0, 2'b00, 16'hA5A5, 4'd3, 2'b10, 0);
    for (int op = 0; op < 4; op++) begin
      run_op(0, 1, 16'h0000, 4'd0, 2'b00, 16'hA5A5, 4'd0, 2'(op), 0);
    end
    run_op(1, 0, 16'hA5A5, 4'd4, 2'b00, 16'h0000, 4'd0, 2'b00, 0);
    run_op(1, 0, 16'h8001, 4'd15, 2'b11, 16'h0000, 4'd0, 2'b00, 0);

    // both valid: alternating grants
    for (int i = 0; i < 6; i++) begin
      run_op(1, 1, 16'h1234, 4'd1, 2'b01, 16'h4321, 4'd2, 2'b10, 0);
    end

    // response back-pressure
    run_op(1, 0, 16'hBEEF, 4'd7, 2'b10, 16'h0000, 4'd0, 2'b00, 5);

    // reset during EXEC1
    req0_valid = 1'b1; req0_data = 16'hFFFF; req0_shamt = 4'd2; req0_op = 2'b01;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    chk("pre_rst_shf_lr", 32'(shf_lr), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    ptr_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(0, 1, 16'h0000, 4'd0, 2'b00, 16'h00F0, 4'd4, 2'b01, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rv  = 2'($urandom_range(1, 3));
      rd0 = 16'($urandom); rs0 = 4'($urandom); ro0 = 2'($urandom);
      rd1 = 16'($urandom); rs1 = 4'($urandom); ro1 = 2'($urandom);
      run_op(rv[0], rv[1], rd0, rs0, ro0, rd1, rs1, ro1, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
